// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding and constants for the program loader.
package prog_loader_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HDR    = 3'd1,
      LOAD   = 3'd2,
      CHK    = 3'd3,
      RUN    = 3'd4,
      HALTED = 3'd5,
      ERR    = 3'd6
   } state_e;

   // Number of little-endian length bytes preceding the payload
   localparam int HDR_BYTES = 4;

   // Saturation ceiling of the run-cycle counter
   localparam logic [31:0] CYC_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte stream handshake plus instruction-memory byte write port.
// The slave side is the loader; the master side is the host that feeds bytes
// and observes the memory writes.
interface prog_loader_if #(
   parameter int ADDR_W = 10
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [7:0]        imem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/prog_loader_rx.sv
// prog_loader_rx: stream receive side of the loader. Owns the handshake, the
// header byte counter, the length register, the byte index, the payload XOR
// accumulator and the registered memory write port. Reports header completion,
// last payload byte and checksum byte as single-cycle strobes to the FSM.
module prog_loader_rx
   import prog_loader_pkg::*;
#(
   parameter int MEM_BYTES = 1024,
   parameter int ADDR_W    = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  state_e       state,
   input  logic         restart,
   prog_loader_if.slave bus,
   output logic         hdr_done,
   output logic         hdr_len_zero,
   output logic         hdr_len_over,
   output logic         byte_last,
   output logic         chk_done,
   output logic         chk_ok
);

   localparam int               CNT_W    = $clog2(HDR_BYTES);
   localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_BYTES - 1);
   localparam logic [31:0]      MEM_LEN  = 32'(MEM_BYTES);

   logic              hs;
   logic [CNT_W-1:0]  hdr_cnt_q, hdr_cnt_d;
   logic [31:0]       len_q, len_d, len_full;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [7:0]        csum_q, csum_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;

   assign bus.in_ready   = (state == HDR) || (state == LOAD) || (state == CHK);
   assign hs             = bus.in_valid & bus.in_ready;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;

   // Next-state of the receive counters and the one-cycle-delayed write port
   always_comb begin
      hdr_cnt_d    = hdr_cnt_q;
      len_d        = len_q;
      idx_d        = idx_q;
      csum_d       = csum_q;
      we_d         = 1'b0;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      hdr_done     = 1'b0;
      byte_last    = 1'b0;
      chk_done     = 1'b0;
      chk_ok       = 1'b0;
      // Length as it stands once the current header byte is merged in
      len_full     = len_q;
      len_full[{hdr_cnt_q, 3'b000} +: 8] = bus.in_data;
      hdr_len_zero = (len_full == 32'd0);
      hdr_len_over = (len_full > MEM_LEN);

      if (restart) begin
         hdr_cnt_d = '0;
         idx_d     = '0;
         csum_d    = '0;
      end else if (hs) begin
         case (state)
            HDR: begin
               len_d     = len_full;
               hdr_cnt_d = hdr_cnt_q + CNT_W'(1);
               hdr_done  = (hdr_cnt_q == HDR_LAST);
            end
            LOAD: begin
               we_d      = 1'b1;
               addr_d    = idx_q;
               wdata_d   = bus.in_data;
               idx_d     = idx_q + ADDR_W'(1);
               csum_d    = csum_q ^ bus.in_data;
               byte_last = (32'(idx_q) == len_q - 32'd1);
            end
            CHK: begin
               chk_done = 1'b1;
               chk_ok   = (bus.in_data == csum_q);
            end
            default: ;
         endcase
      end
   end

   // Receive-side registers; memory contents are not this block's concern
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hdr_cnt_q <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         csum_q    <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         hdr_cnt_q <= hdr_cnt_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         csum_q    <= csum_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: boot loader for the single-cycle CPU. Receives a length-prefixed
// byte image, writes it into instruction memory, then releases the CPU from
// reset and counts run cycles until halt or watchdog expiry.
// Optional trailing XOR checksum byte: define PROG_LOADER_CHECKSUM_EN.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int MEM_BYTES  = 1024,
   parameter int ADDR_W     = 10,
   parameter int MAX_CYCLES = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   prog_loader_if.slave bus,
   output logic         cpu_rst_n,
   input  logic         halt,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic         timeout,
   output logic [31:0]  cycle_count
);

`ifdef PROG_LOADER_CHECKSUM_EN
   localparam state_e AFTER_LOAD = CHK;
`else
   localparam state_e AFTER_LOAD = RUN;
`endif

   localparam bit          WD_EN   = (MAX_CYCLES != 0);
   localparam logic [31:0] WD_LAST = 32'(MAX_CYCLES) - 32'd1;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == CYC_MAX) ? v : v + 32'd1;
   endfunction

   state_e      state_q, state_d;
   logic        cpu_rst_n_q, cpu_rst_n_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        timeout_q, timeout_d;
   logic [31:0] cycle_count_q, cycle_count_d;
   logic        run_first_q, run_first_d;
   logic        restart;
   logic        hdr_done, hdr_len_zero, hdr_len_over;
   logic        byte_last, chk_done, chk_ok;

   prog_loader_rx #(
      .MEM_BYTES (MEM_BYTES),
      .ADDR_W    (ADDR_W)
   ) u_rx (
      .clk          (clk),
      .rst          (rst),
      .state        (state_q),
      .restart      (restart),
      .bus          (bus),
      .hdr_done     (hdr_done),
      .hdr_len_zero (hdr_len_zero),
      .hdr_len_over (hdr_len_over),
      .byte_last    (byte_last),
      .chk_done     (chk_done),
      .chk_ok       (chk_ok)
   );

   assign cpu_rst_n   = cpu_rst_n_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;
   assign timeout     = timeout_q;
   assign cycle_count = cycle_count_q;

   // Loader/run sequencing; flags are derived from the next state so they are registered
   always_comb begin
      state_d       = state_q;
      timeout_d     = timeout_q;
      cycle_count_d = cycle_count_q;
      run_first_d   = run_first_q;
      restart       = 1'b0;

      case (state_q)
         IDLE, HALTED, ERR: begin
            if (start) begin
               state_d   = HDR;
               restart   = 1'b1;
               timeout_d = 1'b0;
            end
         end
         HDR: begin
            if (hdr_done) begin
               if (hdr_len_over)      state_d = ERR;
               else if (hdr_len_zero) state_d = AFTER_LOAD;
               else                   state_d = LOAD;
            end
         end
         LOAD: begin
            if (byte_last) state_d = AFTER_LOAD;
         end
         CHK: begin
            if (chk_done) state_d = chk_ok ? RUN : ERR;
         end
         RUN: begin
            cycle_count_d = sat_inc(cycle_count_q);
            run_first_d   = 1'b0;
            // The CPU is still coming out of reset on the first cycle, so halt is ignored there
            if (!run_first_q && halt) begin
               state_d = HALTED;
            end else if (WD_EN && (cycle_count_q == WD_LAST)) begin
               state_d   = HALTED;
               timeout_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if ((state_d == RUN) && (state_q != RUN)) begin
         cycle_count_d = '0;
         run_first_d   = 1'b1;
      end

      cpu_rst_n_d = (state_d == RUN) || (state_d == HALTED);
      busy_d      = (state_d == HDR) || (state_d == LOAD) || (state_d == CHK) || (state_d == RUN);
      done_d      = (state_d == HALTED);
      err_d       = (state_d == ERR);
   end

   // FSM state and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         cpu_rst_n_q   <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         timeout_q     <= 1'b0;
         cycle_count_q <= '0;
         run_first_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cpu_rst_n_q   <= cpu_rst_n_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_q         <= err_d;
         timeout_q     <= timeout_d;
         cycle_count_q <= cycle_count_d;
         run_first_q   <= run_first_d;
      end
   end

endmodule
